// File: rtl/cpstr_unesc_pkg.sv
// Shared definitions for the cpstr unescaper: byte type, default escape
// character, FSM state encoding and small helpers.
package cpstr_unesc_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned STAT_W_DEF = 16;

    typedef logic [BYTE_W-1:0] byte_t;

    // Escape byte shared with the transmit-side escaper
    localparam byte_t CPSTR_ESC_CHAR = 8'h1B;

    // Receive FSM: waiting for a byte, or holding a pending ESC
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ESC_SEEN = 1'b1
    } state_e;

    // True when the byte matches the configured escape value
    function automatic logic is_esc(input byte_t b, input byte_t esc);
        return b == esc;
    endfunction

endpackage

// File: rtl/cpstr_unesc_if.sv
// Byte-stream bundle for cpstr_unesc: escaped input plus data and emit
// output channels, each with valid/ready.
interface cpstr_unesc_if;
    import cpstr_unesc_pkg::*;

    byte_t i_data;
    logic  i_valid;
    logic  o_ready;
    byte_t o_data;
    logic  o_valid;
    logic  i_ready;
    byte_t o_emit_data;
    logic  o_emit_valid;
    logic  i_emit_ready;
    logic  o_esc_pending;

    // Unescaper side
    modport slave (
        input  i_data, i_valid, i_ready, i_emit_ready,
        output o_ready, o_data, o_valid, o_emit_data, o_emit_valid, o_esc_pending
    );

    // Link receiver / consumer side
    modport master (
        output i_data, i_valid, i_ready, i_emit_ready,
        input  o_ready, o_data, o_valid, o_emit_data, o_emit_valid, o_esc_pending
    );

endinterface

// File: rtl/cpstr_out_reg.sv
// One-entry valid/ready output register. A load fills the slot; the slot
// empties when the consumer takes the byte. o_free_c tells the producer the
// slot can be written this cycle.
module cpstr_out_reg
    import cpstr_unesc_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  byte_t i_load_data,
    input  logic  i_ready,
    output logic  o_valid,
    output byte_t o_data,
    output logic  o_free_c
);

    // Slot is writable when empty or being drained this cycle
    assign o_free_c = !o_valid || i_ready;

    // Hold the byte until the consumer accepts it; data stays put while stalled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_load_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpstr_unesc.sv
// cpstr_unesc: splits an escaped byte stream into a data stream and an
// emit (command) stream. ESC,ESC -> data ESC; ESC,X -> emit X; else data.
// Optional statistics counters are built when CPSTR_UNESC_STATS_EN is defined.
module cpstr_unesc
    import cpstr_unesc_pkg::*;
#(
    parameter byte_t ESC_CHAR = CPSTR_ESC_CHAR
`ifdef CPSTR_UNESC_STATS_EN
    ,
    parameter int unsigned STAT_W = STAT_W_DEF
`endif
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    cpstr_unesc_if.slave bus
`ifdef CPSTR_UNESC_STATS_EN
    ,
    output logic [STAT_W-1:0] o_stat_data,
    output logic [STAT_W-1:0] o_stat_emit
`endif
);

    state_e state;
    logic   accept_c;
    logic   byte_is_esc_c;
    logic   data_free_c;
    logic   emit_free_c;
    logic   data_load_c;
    logic   emit_load_c;
    byte_t  data_load_val_c;

    // Input is taken only when both output slots can absorb whatever it produces
    assign bus.o_ready    = data_free_c && emit_free_c;
    assign accept_c       = bus.i_valid && bus.o_ready;
    assign byte_is_esc_c  = is_esc(bus.i_data, ESC_CHAR);
    assign bus.o_esc_pending = (state == ST_ESC_SEEN);

    // Decode which output register an accepted byte lands in
    always_comb begin
        data_load_c     = 1'b0;
        emit_load_c     = 1'b0;
        data_load_val_c = bus.i_data;
        if (accept_c) begin
            unique case (state)
                ST_IDLE: begin
                    data_load_c = !byte_is_esc_c;
                end
                ST_ESC_SEEN: begin
                    if (byte_is_esc_c) begin
                        data_load_c     = 1'b1;
                        data_load_val_c = ESC_CHAR;
                    end else begin
                        emit_load_c = 1'b1;
                    end
                end
                default: begin
                    data_load_c = 1'b0;
                end
            endcase
        end
    end

    // Escape-tracking FSM; a lone ESC waits indefinitely for its partner
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (accept_c) begin
            unique case (state)
                ST_IDLE:     state <= byte_is_esc_c ? ST_ESC_SEEN : ST_IDLE;
                ST_ESC_SEEN: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Data channel output register
    cpstr_out_reg u_data_reg (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (data_load_c),
        .i_load_data (data_load_val_c),
        .i_ready     (bus.i_ready),
        .o_valid     (bus.o_valid),
        .o_data      (bus.o_data),
        .o_free_c    (data_free_c)
    );

    // Emit channel output register
    cpstr_out_reg u_emit_reg (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (emit_load_c),
        .i_load_data (bus.i_data),
        .i_ready     (bus.i_emit_ready),
        .o_valid     (bus.o_emit_valid),
        .o_data      (bus.o_emit_data),
        .o_free_c    (emit_free_c)
    );

`ifdef CPSTR_UNESC_STATS_EN
    // Count delivered bytes per channel, wrapping at the counter width
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_stat_data <= '0;
            o_stat_emit <= '0;
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                o_stat_data <= o_stat_data + STAT_W'(1);
            end
            if (bus.o_emit_valid && bus.i_emit_ready) begin
                o_stat_emit <= o_stat_emit + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpstr_unesc.sv
// Scoreboard bench for cpstr_unesc: directed byte sequences push expected
// data/emit bytes into queues; a negedge monitor pops and compares on every
// output handshake and checks that stalled outputs hold.
module tb_cpstr_unesc;
    import cpstr_unesc_pkg::*;

    localparam int unsigned TB_STAT_W = 16;

    logic clk;
    logic rst_n;

    cpstr_unesc_if intf ();

`ifdef CPSTR_UNESC_STATS_EN
    logic [TB_STAT_W-1:0] stat_data;
    logic [TB_STAT_W-1:0] stat_emit;
`endif

    cpstr_unesc #(
        .ESC_CHAR (8'h1B)
`ifdef CPSTR_UNESC_STATS_EN
        ,
        .STAT_W   (TB_STAT_W)
`endif
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (intf.slave)
`ifdef CPSTR_UNESC_STATS_EN
        ,
        .o_stat_data (stat_data),
        .o_stat_emit (stat_emit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    byte_t dq[$];
    byte_t eq[$];
    int    esc_cycles = 0;
    logic  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pop and compare on each handshake, verify hold while stalled
    logic  d_stall_prev = 1'b0;
    logic  e_stall_prev = 1'b0;
    byte_t d_prev;
    byte_t e_prev;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            d_stall_prev = 1'b0;
            e_stall_prev = 1'b0;
        end else begin
            if (d_stall_prev) begin
                check("dst_hold_valid", 32'(intf.o_valid), 32'd1);
                check("dst_hold_data", 32'(intf.o_data), 32'(d_prev));
            end
            if (e_stall_prev) begin
                check("emit_hold_valid", 32'(intf.o_emit_valid), 32'd1);
                check("emit_hold_data", 32'(intf.o_emit_data), 32'(e_prev));
            end
            if (intf.o_valid && intf.i_ready) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dst_unexpected: got %0h expected none at %0t", intf.o_data, $time);
                end else begin
                    check("dst_byte", 32'(intf.o_data), 32'(dq.pop_front()));
                end
            end
            if (intf.o_emit_valid && intf.i_emit_ready) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL emit_unexpected: got %0h expected none at %0t", intf.o_emit_data, $time);
                end else begin
                    check("emit_byte", 32'(intf.o_emit_data), 32'(eq.pop_front()));
                end
            end
            if (intf.o_esc_pending) esc_cycles++;
            d_stall_prev = intf.o_valid && !intf.i_ready;
            e_stall_prev = intf.o_emit_valid && !intf.i_emit_ready;
            d_prev = intf.o_data;
            e_prev = intf.o_emit_data;
        end
    end

    // Present one byte and hold it until accepted (bounded wait)
    task automatic send(input byte_t b, output int waits);
        waits = 0;
        intf.i_data  = b;
        intf.i_valid = 1'b1;
        forever begin
            @(negedge clk);
            waits++;
            if (intf.o_ready) break;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, waits);
                break;
            end
        end
        @(posedge clk);
        #1;
        intf.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o_valid"}, 32'(intf.o_valid), 32'd0);
        check({tag, "_o_emit_valid"}, 32'(intf.o_emit_valid), 32'd0);
        check({tag, "_o_esc_pending"}, 32'(intf.o_esc_pending), 32'd0);
        check({tag, "_o_data"}, 32'(intf.o_data), 32'h00);
        check({tag, "_o_emit_data"}, 32'(intf.o_emit_data), 32'h00);
        check({tag, "_o_ready"}, 32'(intf.o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n             = 1'b0;
        intf.i_data       = 8'h00;
        intf.i_valid      = 1'b0;
        intf.i_ready      = 1'b1;
        intf.i_emit_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
`ifdef CPSTR_UNESC_STATS_EN
        check("reset_stat_data", 32'(stat_data), 32'd0);
        check("reset_stat_emit", 32'(stat_emit), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // 1: pass-through, one byte per cycle, output one cycle after accept
        for (int i = 1; i <= 5; i++) begin
            dq.push_back(byte_t'(i));
            send(byte_t'(i), w);
            check("pt_accept_wait", 32'(w), 32'd1);
            check("pt_latency_valid", 32'(intf.o_valid), 32'd1);
            check("pt_latency_data", 32'(intf.o_data), 32'(i));
        end
        idle(3);

        // 2: escaped data byte; ESC pending for exactly one cycle
        esc_cycles = 0;
        dq.push_back(8'h1B);
        dq.push_back(8'h06);
        send(8'h1B, w);
        send(8'h1B, w);
        send(8'h06, w);
        idle(3);
        check("esc_pending_cycles", 32'(esc_cycles), 32'd1);

        // 3: emit byte between data bytes
        dq.push_back(8'h07);
        eq.push_back(8'hBE);
        dq.push_back(8'h08);
        send(8'h07, w);
        send(8'h1B, w);
        send(8'hBE, w);
        send(8'h08, w);
        idle(3);

        // 4: data consumer stall
        dq.push_back(8'h23);
        dq.push_back(8'h24);
        dq.push_back(8'h25);
        intf.i_ready = 1'b0;
        fork
            begin
                send(8'h23, w);
                send(8'h24, w);
                send(8'h25, w);
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_o_ready", 32'(intf.o_ready), 32'd0);
                check("stall_o_valid", 32'(intf.o_valid), 32'd1);
                check("stall_o_data", 32'(intf.o_data), 32'h23);
                @(posedge clk);
                #1;
                intf.i_ready = 1'b1;
            end
        join
        idle(3);

        // 5: emit consumer stall blocks input, then data resumes
        eq.push_back(8'hC0);
        dq.push_back(8'h31);
        dq.push_back(8'h32);
        intf.i_emit_ready = 1'b0;
        fork
            begin
                send(8'h1B, w);
                send(8'hC0, w);
                send(8'h31, w);
                send(8'h32, w);
            end
            begin
                repeat (4) @(negedge clk);
                check("estall_valid", 32'(intf.o_emit_valid), 32'd1);
                check("estall_data", 32'(intf.o_emit_data), 32'hC0);
                check("estall_o_ready", 32'(intf.o_ready), 32'd0);
                @(posedge clk);
                #1;
                intf.i_emit_ready = 1'b1;
            end
        join
        idle(3);

        // 6: reset discards a lone ESC
        send(8'h1B, w);
        idle(2);
        check("lone_esc_pending", 32'(intf.o_esc_pending), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        eq.push_back(8'h11);
        send(8'h1B, w);
        send(8'h11, w);
        idle(3);
`ifdef CPSTR_UNESC_STATS_EN
        check("stat_emit_after_reset", 32'(stat_emit), 32'd1);
        check("stat_data_after_reset", 32'(stat_data), 32'd0);
`endif

        // All expected bytes must have been delivered
        idle(3);
        check("dst_queue_empty", 32'(dq.size()), 32'd0);
        check("emit_queue_empty", 32'(eq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
